incrementer_counter_4bit: RTL

//   Synchronous 4-bit up counter: ripple incrementer (half-adder chain, carry-in 1)

---
 rtl/incrementer_counter_4bit_pkg.sv | 17 +
 rtl/incrementer_counter_4bit_incrementer.sv | 47 ++++
 rtl/incrementer_counter_4bit.sv | 75 +++++++
 3 files changed

// File: rtl/incrementer_counter_4bit_pkg.sv
// Shared constants and next-state select encoding for the 4-bit up counter.
// Imported by the counter top and its incrementer sub-module.
package incrementer_counter_4bit_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MAX_VAL = 15;
    localparam int RESET_VAL       = 0;

    // Which source feeds the count register on the next edge (reset handled in the register itself)
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_INC  = 2'd2,
        SEL_WRAP = 2'd3
    } next_sel_t;

endpackage

// File: rtl/incrementer_counter_4bit_incrementer.sv
// Gate-level cells and the WIDTH-bit ripple incrementer built from them:
// a half-adder chain with the carry-in tied high, so sum = a + 1.
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module and_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module incrementer_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b1;

    // Each stage is a half adder: sum bit from XOR, ripple carry from AND
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        xor_gate u_xor (
            .a (a[i]),
            .b (carry[i]),
            .y (sum[i])
        );
        and_gate u_and (
            .a (a[i]),
            .b (carry[i]),
            .y (carry[i+1])
        );
    end

    assign carry_out = carry[WIDTH];

endmodule

// File: rtl/incrementer_counter_4bit.sv
// Synchronous up counter with parallel load, count enable, programmable wrap
// point (MAX_VAL), terminal-count decode and a one-cycle registered carry pulse.
module incrementer_counter_4bit
    import incrementer_counter_4bit_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MAX_VAL = DEFAULT_MAX_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             co
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] inc_sum;
    logic             inc_carry;
    next_sel_t        sel;
    logic [WIDTH-1:0] next_q;
    logic             next_co;

    incrementer_nbit #(
        .WIDTH (WIDTH)
    ) u_incrementer (
        .a         (q),
        .sum       (inc_sum),
        .carry_out (inc_carry)
    );

    always_comb begin
        sel = SEL_HOLD;
        if (load) begin
            sel = SEL_LOAD;
        end else if (en) begin
            sel = (q == MAX_Q) ? SEL_WRAP : SEL_INC;
        end
    end

    // Values above MAX_VAL count on to the natural rollover, whose MSB carry also fires co
    always_comb begin
        next_q  = q;
        next_co = 1'b0;
        case (sel)
            SEL_LOAD: next_q = d;
            SEL_INC: begin
                next_q  = inc_sum;
                next_co = inc_carry;
            end
            SEL_WRAP: begin
                next_q  = '0;
                next_co = 1'b1;
            end
            default: next_q = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= RESET_Q;
            co <= 1'b0;
        end else begin
            q  <= next_q;
            co <= next_co;
        end
    end

    assign tc = (q == MAX_Q);

endmodule
